// File: rtl/pipe_pkg.sv
// Shared types for the PIPE PHY model: FSM states, power-state encoding of
// the PowerDown field, and receiver-detect status codes.
package pipe_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT = 3'd0,
    STABLE     = 3'd1,
    PWR_CHG    = 3'd2,
    DETECT     = 3'd3,
    DET_HOLD   = 3'd4
  } phy_fsm;

  // Encoding matches the 3-bit PowerDown field driven by the MAC.
  typedef enum logic [2:0] {
    PS_P0  = 3'd0,
    PS_P0S = 3'd1,
    PS_P1  = 3'd2,
    PS_P2  = 3'd3
  } power_states;

  localparam logic [2:0] RXSTAT_DETECTED = 3'b011;
  localparam logic [2:0] RXSTAT_OK       = 3'b000;

  // Only P0, P0s, P1 and P2 are meaningful requests.
  function automatic logic isLegalPowerDown(input logic [2:0] pd);
    return (pd <= 3'd3);
  endfunction

  // The receiver is only powered in P0 and P0s.
  function automatic logic isRxActive(input power_states ps);
    return (ps == PS_P0) || (ps == PS_P0S);
  endfunction

endpackage

// File: rtl/pipe_phy_rx_lane.sv
// Registered receive datapath of the PHY model: polarity inversion of the
// far-end data, the near-end loopback mux and idle forcing when the
// receiver is powered down.
module pipe_phy_rx_lane
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  power_states i_pwr,
  input  logic        i_lpbkEn,
  input  logic [15:0] i_txData,
  input  logic [1:0]  i_txDataK,
  input  logic        i_rxPolarity,
  input  logic [15:0] i_farData,
  input  logic [1:0]  i_farDataK,
  input  logic        i_farValid,
  input  logic        i_farIdle,
  output logic [15:0] o_rxData,
  output logic [1:0]  o_rxDataK,
  output logic        o_rxValid,
  output logic        o_rxElecIdle
);

  logic [15:0] r_rxData;
  logic [1:0]  r_rxDataK;
  logic        r_rxValid;
  logic        r_rxElecIdle;

  logic [15:0] w_rxData;
  logic [1:0]  w_rxDataK;
  logic        w_rxValid;
  logic        w_rxElecIdle;

  // Select the symbol source for the next cycle: idle when powered down,
  // looped-back transmit data, or (optionally inverted) far-end data.
  always_comb begin
    w_rxData     = 16'h0000;
    w_rxDataK    = 2'b00;
    w_rxValid    = 1'b0;
    w_rxElecIdle = 1'b1;
    if (isRxActive(i_pwr)) begin
      if (i_lpbkEn) begin
        w_rxData     = i_txData;
        w_rxDataK    = i_txDataK;
        w_rxValid    = 1'b1;
        w_rxElecIdle = 1'b0;
      end else begin
        w_rxData     = i_farData ^ {16{i_rxPolarity}};
        w_rxDataK    = i_farDataK;
        w_rxValid    = i_farValid;
        w_rxElecIdle = i_farIdle;
      end
    end
  end

  // Register every receive output so the lane has a fixed 1-cycle latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rxData     <= 16'h0000;
      r_rxDataK    <= 2'b00;
      r_rxValid    <= 1'b0;
      r_rxElecIdle <= 1'b1;
    end else begin
      r_rxData     <= w_rxData;
      r_rxDataK    <= w_rxDataK;
      r_rxValid    <= w_rxValid;
      r_rxElecIdle <= w_rxElecIdle;
    end
  end

  assign o_rxData     = r_rxData;
  assign o_rxDataK    = r_rxDataK;
  assign o_rxValid    = r_rxValid;
  assign o_rxElecIdle = r_rxElecIdle;

endmodule

// File: rtl/pipe_phy_model.sv
// PHY side of the PIPE interface: answers PowerDown, receiver-detect and
// loopback requests with timed PhyStatus/RxStatus handshakes and delivers
// far-end receive data so an upstream LTSSM can train against it.
module pipe_phy_model
  import pipe_pkg::*;
#(
  parameter int READY_CYC = 16,
  parameter int PWR_LAT   = 4,
  parameter int DET_LAT   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  PowerDown,
  input  logic        TxDetectRxorLpbk,
  input  logic        TxElecIdle,
  input  logic [15:0] TxData,
  input  logic [1:0]  TxDataK,
  input  logic        RxPolarity,
  input  logic        far_present,
  input  logic [15:0] far_data,
  input  logic [1:0]  far_datak,
  input  logic        far_valid,
  input  logic        far_idle,
  output logic        PhyStatus,
  output logic [2:0]  RxStatus,
  output logic [15:0] RxData,
  output logic [1:0]  RxDataK,
  output logic        RxValid,
  output logic        RxElecIdle,
  output logic        protocol_err
);

  localparam int MAX_LAT = (READY_CYC > PWR_LAT) ?
                           ((READY_CYC > DET_LAT) ? READY_CYC : DET_LAT) :
                           ((PWR_LAT > DET_LAT) ? PWR_LAT : DET_LAT);
  localparam int CNT_W   = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);

  phy_fsm      r_state;
  phy_fsm      w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  power_states r_pwr;
  power_states w_pwrNext;
  power_states r_pwrPend;
  power_states w_pwrPendNext;
  logic        r_phyStatus;
  logic        w_phyStatusNext;
  logic [2:0]  r_rxStatus;
  logic [2:0]  w_rxStatusNext;
  logic        r_protoErr;
  logic        w_protoErrNext;
  logic        w_pdLegal;
  logic        w_lpbkEn;

  assign w_pdLegal = isLegalPowerDown(PowerDown);

  // Next-state, counter, power-state commit and handshake outputs. The
  // counter is loaded on state entry and tested for zero, so a latency of
  // N gives the PhyStatus pulse N+1 cycles after the request is sampled.
  always_comb begin
    w_stateNext     = r_state;
    w_cntNext       = r_cnt;
    w_pwrNext       = r_pwr;
    w_pwrPendNext   = r_pwrPend;
    w_phyStatusNext = 1'b0;
    w_rxStatusNext  = RXSTAT_OK;
    w_protoErrNext  = 1'b0;
    case (r_state)
      RESET_WAIT: begin
        w_phyStatusNext = 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_phyStatusNext = 1'b0;
          w_stateNext     = STABLE;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      STABLE: begin
        if (!w_pdLegal) begin
          w_protoErrNext = 1'b1;
        end
        if (w_pdLegal && (PowerDown != r_pwr)) begin
          w_pwrPendNext = power_states'(PowerDown);
          w_cntNext     = CNT_W'(PWR_LAT);
          w_stateNext   = PWR_CHG;
        end else if ((r_pwr == PS_P1) && TxDetectRxorLpbk) begin
          if (TxElecIdle) begin
            w_cntNext   = CNT_W'(DET_LAT);
            w_stateNext = DETECT;
          end else begin
            w_protoErrNext = 1'b1;
          end
        end
      end
      PWR_CHG: begin
        if (r_cnt == '0) begin
          w_phyStatusNext = 1'b1;
          w_pwrNext       = r_pwrPend;
          w_stateNext     = STABLE;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      DETECT: begin
        if (r_cnt == '0) begin
          w_phyStatusNext = 1'b1;
          w_rxStatusNext  = far_present ? RXSTAT_DETECTED : RXSTAT_OK;
          w_stateNext     = DET_HOLD;
        end else begin
          w_cntNext = r_cnt - CNT_W'(1);
        end
      end
      DET_HOLD: begin
        if (!TxDetectRxorLpbk) begin
          w_stateNext = STABLE;
        end
      end
      default: begin
        w_stateNext = RESET_WAIT;
      end
    endcase
  end

  // State register; reset abandons any pending power change or detect.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= RESET_WAIT;
      r_cnt       <= CNT_W'(READY_CYC);
      r_pwr       <= PS_P1;
      r_pwrPend   <= PS_P1;
      r_phyStatus <= 1'b1;
      r_rxStatus  <= RXSTAT_OK;
      r_protoErr  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_pwr       <= w_pwrNext;
      r_pwrPend   <= w_pwrPendNext;
      r_phyStatus <= w_phyStatusNext;
      r_rxStatus  <= w_rxStatusNext;
      r_protoErr  <= w_protoErrNext;
    end
  end

  // The lane sees the power state being committed this cycle, so the new
  // state is already visible on the receive outputs during the PhyStatus
  // pulse.
  assign w_lpbkEn = (w_pwrNext == PS_P0) && TxDetectRxorLpbk && !TxElecIdle;

  pipe_phy_rx_lane u_rxLane (
    .clk          (clk),
    .rstn         (rstn),
    .i_pwr        (w_pwrNext),
    .i_lpbkEn     (w_lpbkEn),
    .i_txData     (TxData),
    .i_txDataK    (TxDataK),
    .i_rxPolarity (RxPolarity),
    .i_farData    (far_data),
    .i_farDataK   (far_datak),
    .i_farValid   (far_valid),
    .i_farIdle    (far_idle),
    .o_rxData     (RxData),
    .o_rxDataK    (RxDataK),
    .o_rxValid    (RxValid),
    .o_rxElecIdle (RxElecIdle)
  );

  assign PhyStatus    = r_phyStatus;
  assign RxStatus     = r_rxStatus;
  assign protocol_err = r_protoErr;

endmodule

// File: tb/tb_pipe_phy_model.sv
// Directed bench for pipe_phy_model: reset/ready timing, receiver detect,
// power changes, receive path and loopback vectors, illegal requests and
// reset during a detect.
module tb_pipe_phy_model;

  logic        clk = 1'b0;
  logic        rstn;
  logic [2:0]  PowerDown;
  logic        TxDetectRxorLpbk;
  logic        TxElecIdle;
  logic [15:0] TxData;
  logic [1:0]  TxDataK;
  logic        RxPolarity;
  logic        far_present;
  logic [15:0] far_data;
  logic [1:0]  far_datak;
  logic        far_valid;
  logic        far_idle;
  logic        PhyStatus;
  logic [2:0]  RxStatus;
  logic [15:0] RxData;
  logic [1:0]  RxDataK;
  logic        RxValid;
  logic        RxElecIdle;
  logic        protocol_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        pol;
    logic        lpbk;
    logic        txIdle;
    logic [15:0] txData;
    logic [1:0]  txK;
    logic [15:0] farData;
    logic [1:0]  farK;
    logic        farValid;
    logic        farIdle;
    logic [15:0] expData;
    logic [1:0]  expK;
    logic        expValid;
    logic        expIdle;
  } rxVec_t;

  rxVec_t vecs [7];

  pipe_phy_model dut (
    .clk              (clk),
    .rstn             (rstn),
    .PowerDown        (PowerDown),
    .TxDetectRxorLpbk (TxDetectRxorLpbk),
    .TxElecIdle       (TxElecIdle),
    .TxData           (TxData),
    .TxDataK          (TxDataK),
    .RxPolarity       (RxPolarity),
    .far_present      (far_present),
    .far_data         (far_data),
    .far_datak        (far_datak),
    .far_valid        (far_valid),
    .far_idle         (far_idle),
    .PhyStatus        (PhyStatus),
    .RxStatus         (RxStatus),
    .RxData           (RxData),
    .RxDataK          (RxDataK),
    .RxValid          (RxValid),
    .RxElecIdle       (RxElecIdle),
    .protocol_err     (protocol_err)
  );

  // 100 MHz PCLK.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, " PhyStatus"}, 32'(PhyStatus), 1);
    checkOutput({name, " RxStatus"}, 32'(RxStatus), 0);
    checkOutput({name, " RxData"}, 32'(RxData), 0);
    checkOutput({name, " RxDataK"}, 32'(RxDataK), 0);
    checkOutput({name, " RxValid"}, 32'(RxValid), 0);
    checkOutput({name, " RxElecIdle"}, 32'(RxElecIdle), 1);
    checkOutput({name, " protocol_err"}, 32'(protocol_err), 0);
  endtask

  // Request was driven just before the next edge; the pulse must appear
  // exactly lat+1 edges after that sampling edge and not earlier.
  task automatic expectPulse(input string name, input int lat, input logic [2:0] expStat);
    int early;
    early = 0;
    for (int i = 0; i < lat + 1; i++) begin
      tick();
      if (PhyStatus) early++;
    end
    checkOutput({name, " early pulses"}, 32'(early), 0);
    tick();
    checkOutput({name, " PhyStatus pulse"}, 32'(PhyStatus), 1);
    checkOutput({name, " RxStatus"}, 32'(RxStatus), 32'(expStat));
  endtask

  task automatic pulseEnd(input string name);
    tick();
    checkOutput({name, " PhyStatus low"}, 32'(PhyStatus), 0);
    checkOutput({name, " RxStatus cleared"}, 32'(RxStatus), 0);
  endtask

  task automatic watchNoPulse(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (PhyStatus || (RxStatus != 3'b000)) seen++;
    end
    checkOutput({name, " no handshake"}, 32'(seen), 0);
  endtask

  task automatic applyStimulus(input rxVec_t v);
    RxPolarity       = v.pol;
    TxDetectRxorLpbk = v.lpbk;
    TxElecIdle       = v.txIdle;
    TxData           = v.txData;
    TxDataK          = v.txK;
    far_data         = v.farData;
    far_datak        = v.farK;
    far_valid        = v.farValid;
    far_idle         = v.farIdle;
    tick();
    checkOutput({v.name, " RxData"}, 32'(RxData), 32'(v.expData));
    checkOutput({v.name, " RxDataK"}, 32'(RxDataK), 32'(v.expK));
    checkOutput({v.name, " RxValid"}, 32'(RxValid), 32'(v.expValid));
    checkOutput({v.name, " RxElecIdle"}, 32'(RxElecIdle), 32'(v.expIdle));
  endtask

  initial begin
    //        name       pol  lpbk idle txData    txK    farData   farK   fV    fI    expData   expK   eV    eI
    vecs[0] = '{"rx plain",  1'b0, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h1234, 2'b01, 1'b1, 1'b0, 16'h1234, 2'b01, 1'b1, 1'b0};
    vecs[1] = '{"rx inv0",   1'b1, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h0000, 2'b10, 1'b1, 1'b0, 16'hFFFF, 2'b10, 1'b1, 1'b0};
    vecs[2] = '{"rx invBC",  1'b1, 1'b0, 1'b1, 16'h0000, 2'b00, 16'hBC1C, 2'b00, 1'b1, 1'b0, 16'h43E3, 2'b00, 1'b1, 1'b0};
    vecs[3] = '{"rx idle",   1'b0, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h5555, 2'b00, 1'b0, 1'b1, 16'h5555, 2'b00, 1'b0, 1'b1};
    vecs[4] = '{"lpbk 4A",   1'b1, 1'b1, 1'b0, 16'h4A4A, 2'b00, 16'hA5A5, 2'b01, 1'b0, 1'b1, 16'h4A4A, 2'b00, 1'b1, 1'b0};
    vecs[5] = '{"lpbk K",    1'b0, 1'b1, 1'b0, 16'hBCBC, 2'b11, 16'h0F0F, 2'b00, 1'b0, 1'b1, 16'hBCBC, 2'b11, 1'b1, 1'b0};
    vecs[6] = '{"no lpbk",   1'b0, 1'b1, 1'b1, 16'h9999, 2'b11, 16'h00FF, 2'b00, 1'b1, 1'b0, 16'h00FF, 2'b00, 1'b1, 1'b0};

    rstn             = 1'b0;
    PowerDown        = 3'd2;
    TxDetectRxorLpbk = 1'b0;
    TxElecIdle       = 1'b1;
    TxData           = 16'h0000;
    TxDataK          = 2'b00;
    RxPolarity       = 1'b0;
    far_present      = 1'b0;
    far_data         = 16'h0000;
    far_datak        = 2'b00;
    far_valid        = 1'b0;
    far_idle         = 1'b1;

    // Reset values and ready timing.
    repeat (3) tick();
    checkResetValues("reset");
    rstn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput($sformatf("ready edge %0d", i), 32'(PhyStatus), (i < 16) ? 32'd1 : 32'd0);
    end
    checkOutput("ready RxElecIdle", 32'(RxElecIdle), 1);
    tick();

    // Receiver detect with and without a far-end termination.
    far_present      = 1'b1;
    TxDetectRxorLpbk = 1'b1;
    expectPulse("detect present", 8, 3'b011);
    pulseEnd("detect present");
    TxDetectRxorLpbk = 1'b0;
    tick();
    far_present      = 1'b0;
    TxDetectRxorLpbk = 1'b1;
    expectPulse("detect absent", 8, 3'b000);
    pulseEnd("detect absent");
    TxDetectRxorLpbk = 1'b0;
    tick();

    // P1 -> P0, receive path switches on in the PhyStatus cycle.
    far_data   = 16'hBC1C;
    RxPolarity = 1'b1;
    far_valid  = 1'b1;
    far_idle   = 1'b0;
    PowerDown  = 3'd0;
    expectPulse("pwr P1->P0", 4, 3'b000);
    checkOutput("pwr P0 RxData", 32'(RxData), 32'h43E3);
    checkOutput("pwr P0 RxValid", 32'(RxValid), 1);
    pulseEnd("pwr P1->P0");

    // Receive and loopback vectors in P0.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end
    TxDetectRxorLpbk = 1'b0;
    TxElecIdle       = 1'b1;
    tick();

    // Back to P1: receiver forced idle.
    PowerDown = 3'd2;
    expectPulse("pwr P0->P1", 4, 3'b000);
    checkOutput("pwr P1 RxValid", 32'(RxValid), 0);
    checkOutput("pwr P1 RxElecIdle", 32'(RxElecIdle), 1);
    checkOutput("pwr P1 RxData", 32'(RxData), 0);
    pulseEnd("pwr P0->P1");

    // Power change and detect requested together: power change wins.
    far_present      = 1'b1;
    PowerDown        = 3'd3;
    TxDetectRxorLpbk = 1'b1;
    expectPulse("simultaneous", 4, 3'b000);
    pulseEnd("simultaneous");
    watchNoPulse("simultaneous after", 12);
    TxDetectRxorLpbk = 1'b0;
    tick();

    // Illegal PowerDown value in P2.
    PowerDown = 3'd5;
    tick();
    checkOutput("illegal pd err", 32'(protocol_err), 1);
    PowerDown = 3'd3;
    tick();
    checkOutput("illegal pd err clear", 32'(protocol_err), 0);
    watchNoPulse("illegal pd ignored", 8);

    // Back to P1, then a detect with the transmitter not idle.
    PowerDown = 3'd2;
    expectPulse("pwr P2->P1", 4, 3'b000);
    pulseEnd("pwr P2->P1");
    TxElecIdle       = 1'b0;
    TxDetectRxorLpbk = 1'b1;
    tick();
    checkOutput("illegal detect err", 32'(protocol_err), 1);
    TxDetectRxorLpbk = 1'b0;
    TxElecIdle       = 1'b1;
    tick();
    checkOutput("illegal detect err clear", 32'(protocol_err), 0);
    watchNoPulse("illegal detect ignored", 10);

    // Reset in the middle of a detect.
    far_present      = 1'b1;
    TxDetectRxorLpbk = 1'b1;
    tick();
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    checkResetValues("mid-detect reset");
    TxDetectRxorLpbk = 1'b0;
    begin : midDetectWatch
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (RxStatus != 3'b000 || !PhyStatus) seen++;
      end
      checkOutput("mid-detect no result", 32'(seen), 0);
    end
    rstn = 1'b1;
    repeat (16) tick();
    checkOutput("re-ready PhyStatus", 32'(PhyStatus), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
